// File: rtl/mixcolumn_stream.sv
// mixcolumn_stream: byte-serial AES MixColumns / InvMixColumns engine.
// Collects one 4-byte column over a LANES-wide valid/ready stream, then
// transforms it into a double-buffered output register that drains in the
// same lane order. The next column is accepted while the previous one drains.
// Optional build macro MIXCOL_BYPASS_EN adds in_bypass. When that bypass is
// held high, columns pass through unchanged (AES final round).
module mixcolumn_stream #(
  parameter int LANES = 1,
  parameter int NB    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
`ifdef MIXCOL_BYPASS_EN
  input  logic               in_bypass,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_last,
  output logic               busy
);

  localparam int         BPC       = 4 / LANES;
  localparam int         W         = 8 * LANES;
  localparam logic [1:0] BEAT_LAST = 2'(BPC - 1);
  localparam logic [2:0] COL_LAST  = 3'(NB - 1);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("mixcolumn_stream: LANES must be 1, 2 or 4");
    end
    if (NB < 1 || NB > 8) begin : g_bad_nb
      $error("mixcolumn_stream: NB must be in 1..8");
    end
  endgenerate

  typedef enum logic {ACC, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  beat_reg;
  logic [2:0]  col_reg;
  logic        inv_reg;
  logic        hold_last_reg;
  logic [31:0] acc_reg;
  logic [31:0] obuf_reg;
  logic        ofull_reg;
  logic        olast_reg;
  logic [1:0]  obeat_reg;
`ifdef MIXCOL_BYPASS_EN
  logic        byp_reg;
`endif

  logic        in_fire;
  logic        out_fire;
  logic        out_drain;
  logic        buf_free;
  logic        first_beat;
  logic        load_buf;
  logic        load_last;
  logic        use_inv;
  logic        use_byp;
  logic [31:0] merged_col;
  logic [31:0] src_col;
  logic [31:0] fwd_col;
  logic [31:0] inv_col;
  logic [31:0] res_col;

  // GF(2^8) multiply-by-two, reduction polynomial 0x11B
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = ofull_reg && out_ready;
  assign out_drain  = out_fire && (obeat_reg == BEAT_LAST);
  assign buf_free   = !ofull_reg || out_drain;
  assign first_beat = (beat_reg == 2'd0) && (col_reg == 3'd0);

  // Current column with this beat's bytes dropped into their slot
  always_comb begin
    merged_col = acc_reg;
    merged_col[int'(beat_reg) * W +: W] = in_data;
  end

  // A parked column comes from the accumulator; otherwise the completing beat
  assign src_col = (state_reg == HOLD) ? acc_reg : merged_col;

  // Mode for the column being transferred. On the first beat of a state the
  // register is only being loaded, so the live input is used instead.
  always_comb begin
    use_inv = inv_reg;
    use_byp = 1'b0;
`ifdef MIXCOL_BYPASS_EN
    use_byp = byp_reg;
`endif
    if (state_reg == ACC && first_beat) begin
      use_inv = in_inv;
`ifdef MIXCOL_BYPASS_EN
      use_byp = in_bypass;
`endif
    end
  end

  // Per-byte forward and inverse column transforms
  logic [7:0] a_b  [4];
  logic [7:0] x2_b [4];
  logic [7:0] x4_b [4];
  logic [7:0] x8_b [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign a_b[gi]  = src_col[8*gi +: 8];
      assign x2_b[gi] = xt(a_b[gi]);
      assign x4_b[gi] = xt(x2_b[gi]);
      assign x8_b[gi] = xt(x4_b[gi]);
      assign fwd_col[8*gi +: 8] = x2_b[gi]
                                ^ (x2_b[(gi+1)%4] ^ a_b[(gi+1)%4])
                                ^ a_b[(gi+2)%4]
                                ^ a_b[(gi+3)%4];
      assign inv_col[8*gi +: 8] = (x8_b[gi] ^ x4_b[gi] ^ x2_b[gi])
                                ^ (x8_b[(gi+1)%4] ^ x2_b[(gi+1)%4] ^ a_b[(gi+1)%4])
                                ^ (x8_b[(gi+2)%4] ^ x4_b[(gi+2)%4] ^ a_b[(gi+2)%4])
                                ^ (x8_b[(gi+3)%4] ^ a_b[(gi+3)%4]);
    end
  endgenerate

  assign res_col = use_byp ? src_col : (use_inv ? inv_col : fwd_col);

  // Accumulator FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACC;
    end else begin
      state_reg <= state_next;
    end
  end

  // Accumulator FSM: input handshake and hand-off into the output buffer
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    load_buf   = 1'b0;
    load_last  = hold_last_reg;
    case (state_reg)
      ACC: begin
        in_ready = !rst;
        if (in_valid && !rst && beat_reg == BEAT_LAST) begin
          load_last = (col_reg == COL_LAST);
          if (buf_free) begin
            load_buf = 1'b1;
          end else begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (buf_free) begin
          load_buf   = 1'b1;
          state_next = ACC;
        end
      end
    endcase
  end

  // Accumulator storage, beat/column counters and per-state mode capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg       <= '0;
      beat_reg      <= '0;
      col_reg       <= '0;
      inv_reg       <= 1'b0;
      hold_last_reg <= 1'b0;
`ifdef MIXCOL_BYPASS_EN
      byp_reg       <= 1'b0;
`endif
    end else if (in_fire) begin
      acc_reg  <= merged_col;
      beat_reg <= (beat_reg == BEAT_LAST) ? 2'd0 : beat_reg + 2'd1;
      if (beat_reg == BEAT_LAST) begin
        col_reg       <= (col_reg == COL_LAST) ? 3'd0 : col_reg + 3'd1;
        hold_last_reg <= (col_reg == COL_LAST);
      end
      if (first_beat) begin
        inv_reg <= in_inv;
`ifdef MIXCOL_BYPASS_EN
        byp_reg <= in_bypass;
`endif
      end
    end
  end

  // Output buffer: load a finished column, else shift one beat out per handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obuf_reg  <= '0;
      ofull_reg <= 1'b0;
      olast_reg <= 1'b0;
      obeat_reg <= '0;
    end else if (load_buf) begin
      obuf_reg  <= res_col;
      ofull_reg <= 1'b1;
      olast_reg <= load_last;
      obeat_reg <= 2'd0;
    end else if (out_fire) begin
      obuf_reg  <= obuf_reg >> W;
      obeat_reg <= (obeat_reg == BEAT_LAST) ? 2'd0 : obeat_reg + 2'd1;
      if (obeat_reg == BEAT_LAST) begin
        ofull_reg <= 1'b0;
      end
    end
  end

  assign out_valid = ofull_reg;
  assign out_data  = obuf_reg[W-1:0];
  assign out_last  = ofull_reg && (obeat_reg == BEAT_LAST) && olast_reg;
  assign busy      = (beat_reg != 2'd0) || (state_reg == HOLD) || ofull_reg;

endmodule

// File: doc/mixcolumn_stream.md
Name: mixcolumn_stream

Overview:
- Parametrised byte-serial MixColumns/InvMixColumns engine for the 8-bit-path AES core, sitting between ShiftRows and AddRoundKey.
- Accepts column bytes over a valid/ready stream, LANES bytes per beat, and accumulates one 4-byte column.
- Computes the forward or inverse column transform, selected at run time.
- Emits the result column over a double-buffered output stream, so the next column is accepted while the previous one drains.

Parameters:
- LANES, 1, bytes per beat; legal values 1, 2, 4; elaboration error otherwise.
- NB, 4, columns per AES state; sets out_last spacing; legal 1..8.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  8*LANES  column bytes; lane 0 = bits [7:0] = lowest-index byte of the beat
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled on first beat of each state
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat consumed when out_valid && out_ready
- out_data  out  8*LANES  result bytes, same lane/byte ordering as input
- out_last  out  1  high on final beat of column NB-1 of a state
- busy  out  1  any column held in accumulator or output buffer

Behaviour:
- Column bytes a0..a3 arrive in index order; BPC = 4/LANES beats per column.
- Forward: b_i = 02·a_i ^ 03·a_(i+1) ^ a_(i+2) ^ a_(i+3), indices mod 4, GF(2^8) with polynomial 0x11B.
- Inverse: b_i = 0E·a_i ^ 0B·a_(i+1) ^ 0D·a_(i+2) ^ 09·a_(i+3).
- Accumulator: beat counter 0..BPC-1 and column counter 0..NB-1.
  - Both counters wrap to 0 after the last value.
  - The column counter advances when a column completes.
- Mode register:
  - Loaded from in_inv on the accepted beat with beat=0 and column=0.
  - Held for all NB columns of that state.
  - in_inv changes mid-state are ignored.
- Accumulator FSM has states ACC and HOLD.
  - ACC: in_ready=1. Each accepted beat stores its bytes.
  - On the last beat of a column, the full column is transferred to the output buffer in that same edge if the buffer is empty, or is being emptied this cycle (last output beat handshaken). State stays ACC.
  - Otherwise the FSM goes to HOLD.
  - HOLD: in_ready=0. The FSM leaves HOLD on the edge where the output buffer frees, transferring the column and returning to ACC.
- Output buffer:
  - Stores the computed column plus a last-column flag.
  - out_valid=1 while it is full.
  - Beats are presented b0 first; the output beat counter advances on each handshake.
  - out_data is stable while out_valid && !out_ready.
- Latency: last input beat of a column accepted at edge t gives out_valid=1 with the first result beat after edge t.
- Throughput: one beat per cycle sustained when out_ready=1.
- out_last = out_valid && (output beat = BPC-1) && column flag = NB-1.
- Transform logic is combinational from the accumulator into the buffer; the result is registered in the buffer, and out_data is taken from registers only.
- Simultaneous transfer into the buffer and final drain of the buffer in one edge is legal; no bubble results.
- Reset (asynchronous assertion, synchronous-safe release):
  - in_ready=0 while rst=1; in_ready=1 the first cycle after release.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - All counters, mode and buffers go to 0; FSM goes to ACC.
  - Reset mid-column discards partial and buffered data; no output beat follows.
- busy = (beat counter != 0) || HOLD || out_valid.

Optional Feature:
- Macro: MIXCOL_BYPASS_EN.
- When defined:
  - Adds input port in_bypass (1 bit), sampled and held exactly like in_inv.
  - When held 1, columns pass through unchanged (b_i = a_i) for AES final-round use, with identical latency and handshake.
  - Bypass overrides in_inv.
- When undefined: no in_bypass port and no bypass mux; the transform always applies.

Test Plan:
- LANES=1, forward, column db 13 53 45 with out_ready=1 -> out bytes 8e 4d a1 bc; first out_valid one cycle after the 4th input beat.
- LANES=4, forward, state columns f2 0a 22 5c, 01 01 01 01, c6 c6 c6 c6, d4 d4 d4 d5 -> 9f dc 58 9d, 01 01 01 01, c6 c6 c6 c6, d5 d5 d7 d6; out_last only on the 4th beat; back-to-back beats, no stall.
- Inverse, LANES=2, in_inv=1: 8e 4d a1 bc -> db 13 53 45. Toggling in_inv during columns 1..3 still yields inverse results for all four columns.
- Backpressure: out_ready=0 for 10 cycles while 2 columns are fed -> second column parks in HOLD, in_ready=0; on release both columns are emitted in order, with no loss or duplication.
- Reset: assert rst after 2 of 4 input beats (LANES=1) -> out_valid=0 and busy=0 immediately. Then feed 2d 26 31 4c -> 4d 7e bd f8.
- With MIXCOL_BYPASS_EN, in_bypass=1: db 13 53 45 -> db 13 53 45.
